// File: rtl/gcd.sv
// Iterative binary (Stein) GCD engine: shifts, compares and subtracts only, one step per clock.
// Optional macro GCD_SUB_SHIFT_EN fuses the odd-odd subtract with a halving of the difference.
module gcd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             go,
  output logic [WIDTH-1:0] gcd_out,
  output logic             done
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             done_q, done_d;

  logic             x_ge_y;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] diff_step;

  // Difference of two odd values is always even, so halving it loses nothing.
  assign x_ge_y = (x_q >= y_q);
  assign diff   = x_ge_y ? (x_q - y_q) : (y_q - x_q);
`ifdef GCD_SUB_SHIFT_EN
  assign diff_step = diff >> 1;
`else
  assign diff_step = diff;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    gcd_d   = gcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          x_d     = a;
          y_d     = b;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (x_q == '0) begin
          gcd_d   = y_q << k_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (y_q == '0) begin
          gcd_d   = x_q << k_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_ge_y) begin
          x_d = diff_step;
        end else begin
          y_d = diff_step;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      gcd_q   <= gcd_d;
      done_q  <= done_d;
    end
  end

  assign gcd_out = gcd_q;
  assign done    = done_q;

endmodule

// File: tb/tb_gcd.sv
// Self-checking bench for gcd: directed corner cases, reset, held-go and randomized pairs
// compared against a Euclid-based reference gcd.
module tb_gcd;
  localparam int WIDTH   = 8;
  localparam int MAX_LAT = 4 * WIDTH + 2;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             go;
  logic [WIDTH-1:0] gcd_out;
  logic             done;

  int tests_run;
  int fail_count;

  gcd #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .clr     (clr),
    .a       (a),
    .b       (b),
    .go      (go),
    .gcd_out (gcd_out),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_gcd(input int p, input int q);
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // One computation with a single-cycle go pulse; returns latency and whether done arrived.
  task automatic run_one(input int av, input int bv, output int lat, output bit got);
    @(negedge clk);
    a  = av[WIDTH-1:0];
    b  = bv[WIDTH-1:0];
    go = 1'b1;
    @(negedge clk);
    go  = 1'b0;
    lat = 1;
    got = 1'b0;
    while (lat <= MAX_LAT + 4) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_one(input string name, input int av, input int bv);
    int lat;
    bit got;
    int exp_v;
    exp_v = ref_gcd(av, bv);
    run_one(av, bv, lat, got);
    tests_run++;
    if (!got) begin
      fail_count++;
      $display("FAIL %s timeout: a=%0d b=%0d no done after %0d cycles", name, av, bv, lat);
      return;
    end
    tests_run++;
    if (gcd_out !== exp_v[WIDTH-1:0]) begin
      fail_count++;
      $display("FAIL %s value: a=%0d b=%0d got %0d expected %0d", name, av, bv, gcd_out, exp_v);
    end
    tests_run++;
    if (lat > MAX_LAT) begin
      fail_count++;
      $display("FAIL %s latency: a=%0d b=%0d got %0d expected <= %0d", name, av, bv, lat, MAX_LAT);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || gcd_out !== exp_v[WIDTH-1:0]) begin
      fail_count++;
      $display("FAIL %s pulse/hold: done=%b gcd_out=%0d expected done=0 gcd_out=%0d",
               name, done, gcd_out, exp_v);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    go  = 1'b0;
    a   = '0;
    b   = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (gcd_out !== '0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_hold: gcd_out=%0d done=%b expected 0/0", gcd_out, done);
    end
    clr = 1'b1;
    a   = 8'd9;
    b   = 8'd24;
    repeat (6) begin
      @(negedge clk);
      tests_run++;
      if (gcd_out !== '0 || done !== 1'b0) begin
        fail_count++;
        $display("FAIL reset_idle: gcd_out=%0d done=%b expected 0/0", gcd_out, done);
      end
    end
  endtask

  task automatic test_directed();
    check_one("d_9_24", 9, 24);
    check_one("d_0_0", 0, 0);
    check_one("d_0_17", 0, 17);
    check_one("d_200_0", 200, 0);
    check_one("d_96_64", 96, 64);
    check_one("d_255_255", 255, 255);
    check_one("d_255_254", 255, 254);
    check_one("d_128_128", 128, 128);
    check_one("d_1_255", 1, 255);
  endtask

  task automatic test_clr_mid_calc();
    @(negedge clk);
    a  = 8'd255;
    b  = 8'd254;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    tests_run++;
    if (gcd_out !== '0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL clr_mid: gcd_out=%0d done=%b expected 0/0", gcd_out, done);
    end
    repeat (MAX_LAT) begin
      @(negedge clk);
      if (done !== 1'b0) begin
        tests_run++;
        fail_count++;
        $display("FAIL clr_abandon: done=%b during reset expected 0", done);
        break;
      end
    end
    clr = 1'b1;
    repeat (MAX_LAT) @(negedge clk);
    tests_run++;
    if (gcd_out !== '0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL clr_no_resume: gcd_out=%0d done=%b expected 0/0", gcd_out, done);
    end
    check_one("after_clr_12_18", 12, 18);
  endtask

  // Waits for the next done pulse within one latency budget; returns whether it came.
  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < MAX_LAT + 2; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_go_held();
    bit got;
    bit seen7;
    @(negedge clk);
    a  = 8'd9;
    b  = 8'd24;
    go = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_done(got);
      tests_run++;
      if (!got || gcd_out !== 8'd3) begin
        fail_count++;
        $display("FAIL held_9_24 pulse %0d: got_done=%b gcd_out=%0d expected 1/3", n, got, gcd_out);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0) begin
        fail_count++;
        $display("FAIL held_pulse_width %0d: done=%b expected 0", n, done);
      end
    end
    a     = 8'd14;
    b     = 8'd21;
    seen7 = 1'b0;
    for (int n = 0; n < 2 && !seen7; n++) begin
      wait_done(got);
      if (got && gcd_out == 8'd7) seen7 = 1'b1;
    end
    tests_run++;
    if (!seen7) begin
      fail_count++;
      $display("FAIL held_14_21: gcd_out=%0d expected 7 within two runs", gcd_out);
    end
    wait_done(got);
    tests_run++;
    if (!got || gcd_out !== 8'd7) begin
      fail_count++;
      $display("FAIL held_repeat: got_done=%b gcd_out=%0d expected 1/7", got, gcd_out);
    end
    go = 1'b0;
    repeat (MAX_LAT + 2) @(negedge clk);
  endtask

  task automatic test_random();
    int av;
    int bv;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       begin av = 0; bv = int'($urandom_range(0, 255)); end
        1:       begin av = int'($urandom_range(0, 255)); bv = 0; end
        2:       begin av = int'($urandom_range(1, 15)) << $urandom_range(0, 4);
                       bv = int'($urandom_range(1, 15)) << $urandom_range(0, 4); end
        default: begin av = int'($urandom_range(0, 255)); bv = int'($urandom_range(0, 255)); end
      endcase
      av = av & 255;
      bv = bv & 255;
      check_one("rand", av, bv);
    end
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    test_reset();
    test_directed();
    test_clr_mid_calc();
    test_go_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
